// File: rtl/tr_rst_seq.sv
// Transceiver reset sequencer: one shared TX/fPLL FSM and one independent RX FSM per channel.
// Define TR_RST_SEQ_LOCKLOSS_EN to make a CDR lock loss in RX_RDY trigger a full RX analog re-reset.
module tr_rst_seq #(
  parameter int NUM_CH   = 1,
  parameter int T_PLL_PD = 1000,
  parameter int T_RX_ANA = 100,
  parameter int T_TX_DIG = 20,
  parameter int T_RX_LTD = 10000
) (
  input  logic              clk_glbl,
  input  logic              rst_glbl_n,
  output logic              pll_powerdown,
  input  logic              pll_locked,
  input  logic              pll_cal_busy,
  input  logic [NUM_CH-1:0] tx_cal_busy,
  output logic [NUM_CH-1:0] tx_analogreset,
  output logic [NUM_CH-1:0] tx_digitalreset,
  output logic [NUM_CH-1:0] tx_ready,
  input  logic [NUM_CH-1:0] rx_cal_busy,
  input  logic [NUM_CH-1:0] rx_is_lockedtodata,
  input  logic [NUM_CH-1:0] rx_rst_req,
  output logic [NUM_CH-1:0] rx_analogreset,
  output logic [NUM_CH-1:0] rx_digitalreset,
  output logic [NUM_CH-1:0] rx_ready
);

  localparam int T_MAX_A = (T_PLL_PD > T_RX_ANA) ? T_PLL_PD : T_RX_ANA;
  localparam int T_MAX_B = (T_TX_DIG > T_RX_LTD) ? T_TX_DIG : T_RX_LTD;
  localparam int T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
  localparam int CW      = $clog2(T_MAX + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t PLL_PD_LAST = cnt_t'(T_PLL_PD - 1);
  localparam cnt_t RX_ANA_LAST = cnt_t'(T_RX_ANA - 1);
  localparam cnt_t TX_DIG_CNT  = cnt_t'(T_TX_DIG);
  localparam cnt_t RX_LTD_CNT  = cnt_t'(T_RX_LTD);

  typedef enum logic [2:0] {PLL_PD, TX_CAL, TX_LOCK, TX_DIG, TX_RDY} tx_state_e;
  typedef enum logic [1:0] {RX_ANA, RX_CAL, RX_LTD, RX_RDY} rx_state_e;

  function automatic cnt_t sat_inc(input cnt_t c);
    return (c == {CW{1'b1}}) ? c : c + cnt_t'(1);
  endfunction

  // ---------------------------------------------------------------------------
  // Two-flop synchronisers for every asynchronous status input
  // ---------------------------------------------------------------------------
  localparam int SW = 2 + 3 * NUM_CH;

  logic [SW-1:0]     sync_in, sync1_q, sync2_q;
  logic              pll_locked_s, pll_cal_busy_s;
  logic [NUM_CH-1:0] tx_cal_busy_s, rx_cal_busy_s, rx_ltd_s;

  assign sync_in = {rx_is_lockedtodata, rx_cal_busy, tx_cal_busy, pll_cal_busy, pll_locked};

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_glbl or negedge rst_glbl_n) begin
    if (!rst_glbl_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync_in;
      sync2_q <= sync1_q;
    end
  end

  assign pll_locked_s   = sync2_q[0];
  assign pll_cal_busy_s = sync2_q[1];
  assign tx_cal_busy_s  = sync2_q[2 +: NUM_CH];
  assign rx_cal_busy_s  = sync2_q[2 + NUM_CH +: NUM_CH];
  assign rx_ltd_s       = sync2_q[2 + 2 * NUM_CH +: NUM_CH];

  // ---------------------------------------------------------------------------
  // Shared TX / fPLL sequencer
  // ---------------------------------------------------------------------------
  tx_state_e         tx_state_q, tx_state_d;
  cnt_t              tx_cnt_q, tx_cnt_d;
  logic              pll_powerdown_q, pll_powerdown_d;
  logic [NUM_CH-1:0] tx_analogreset_q, tx_analogreset_d;
  logic [NUM_CH-1:0] tx_digitalreset_q, tx_digitalreset_d;
  logic [NUM_CH-1:0] tx_ready_q, tx_ready_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    unique case (tx_state_q)
      PLL_PD: begin
        if (tx_cnt_q >= PLL_PD_LAST) begin
          tx_state_d = TX_CAL;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = sat_inc(tx_cnt_q);
        end
      end
      TX_CAL: begin
        if (!pll_cal_busy_s && !(|tx_cal_busy_s)) tx_state_d = TX_LOCK;
      end
      TX_LOCK: begin
        if (pll_locked_s) begin
          tx_state_d = TX_DIG;
          tx_cnt_d   = '0;
        end
      end
      TX_DIG: begin
        if (!pll_locked_s) begin
          tx_state_d = TX_LOCK;
          tx_cnt_d   = '0;
        end else if (sat_inc(tx_cnt_q) >= TX_DIG_CNT) begin
          tx_state_d = TX_RDY;
          tx_cnt_d   = '0;
        end else begin
          tx_cnt_d = sat_inc(tx_cnt_q);
        end
      end
      TX_RDY: begin
        if (!pll_locked_s) tx_state_d = TX_LOCK;
      end
      default: begin
        tx_state_d = PLL_PD;
        tx_cnt_d   = '0;
      end
    endcase
  end

  // Outputs decode the current state and are registered, so they follow a transition by one cycle.
  always_comb begin
    pll_powerdown_d   = (tx_state_q == PLL_PD);
    tx_analogreset_d  = {NUM_CH{tx_state_q inside {PLL_PD, TX_CAL}}};
    tx_digitalreset_d = {NUM_CH{tx_state_q != TX_RDY}};
    tx_ready_d        = {NUM_CH{tx_state_q == TX_RDY}};
  end

  always_ff @(posedge clk_glbl or negedge rst_glbl_n) begin
    if (!rst_glbl_n) begin
      tx_state_q        <= PLL_PD;
      tx_cnt_q          <= '0;
      pll_powerdown_q   <= 1'b1;
      tx_analogreset_q  <= '1;
      tx_digitalreset_q <= '1;
      tx_ready_q        <= '0;
    end else begin
      tx_state_q        <= tx_state_d;
      tx_cnt_q          <= tx_cnt_d;
      pll_powerdown_q   <= pll_powerdown_d;
      tx_analogreset_q  <= tx_analogreset_d;
      tx_digitalreset_q <= tx_digitalreset_d;
      tx_ready_q        <= tx_ready_d;
    end
  end

  assign pll_powerdown   = pll_powerdown_q;
  assign tx_analogreset  = tx_analogreset_q;
  assign tx_digitalreset = tx_digitalreset_q;
  assign tx_ready        = tx_ready_q;

  // ---------------------------------------------------------------------------
  // Per-channel RX sequencers (independent of TX state)
  // ---------------------------------------------------------------------------
  rx_state_e         rx_state_q [NUM_CH];
  rx_state_e         rx_state_d [NUM_CH];
  cnt_t              rx_cnt_q   [NUM_CH];
  cnt_t              rx_cnt_d   [NUM_CH];
  logic [NUM_CH-1:0] rx_analogreset_q, rx_analogreset_d;
  logic [NUM_CH-1:0] rx_digitalreset_q, rx_digitalreset_d;
  logic [NUM_CH-1:0] rx_ready_q, rx_ready_d;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    for (int i = 0; i < NUM_CH; i++) begin
      // A soft request wins over any transition the channel would otherwise take.
      if (rx_rst_req[i]) begin
        rx_state_d[i] = RX_ANA;
        rx_cnt_d[i]   = '0;
      end else begin
        unique case (rx_state_q[i])
          RX_ANA: begin
            if (rx_cnt_q[i] >= RX_ANA_LAST) begin
              rx_state_d[i] = RX_CAL;
              rx_cnt_d[i]   = '0;
            end else begin
              rx_cnt_d[i] = sat_inc(rx_cnt_q[i]);
            end
          end
          RX_CAL: begin
            if (!rx_cal_busy_s[i]) begin
              rx_state_d[i] = RX_LTD;
              rx_cnt_d[i]   = '0;
            end
          end
          RX_LTD: begin
            if (!rx_ltd_s[i]) begin
              rx_cnt_d[i] = '0;
            end else if (sat_inc(rx_cnt_q[i]) >= RX_LTD_CNT) begin
              rx_state_d[i] = RX_RDY;
              rx_cnt_d[i]   = '0;
            end else begin
              rx_cnt_d[i] = sat_inc(rx_cnt_q[i]);
            end
          end
          RX_RDY: begin
            if (!rx_ltd_s[i]) begin
`ifdef TR_RST_SEQ_LOCKLOSS_EN
              rx_state_d[i] = RX_ANA;
`else
              rx_state_d[i] = RX_LTD;
`endif
              rx_cnt_d[i] = '0;
            end
          end
          default: begin
            rx_state_d[i] = RX_ANA;
            rx_cnt_d[i]   = '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    rx_analogreset_d  = '0;
    rx_digitalreset_d = '0;
    rx_ready_d        = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rx_analogreset_d[i]  = rx_state_q[i] inside {RX_ANA, RX_CAL};
      rx_digitalreset_d[i] = (rx_state_q[i] != RX_RDY);
      rx_ready_d[i]        = (rx_state_q[i] == RX_RDY);
    end
  end

  // NOTE: the per-channel state/counter arrays are control state, not storage, so each element is reset.
  always_ff @(posedge clk_glbl or negedge rst_glbl_n) begin
    if (!rst_glbl_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        rx_state_q[i] <= RX_ANA;
        rx_cnt_q[i]   <= '0;
      end
      rx_analogreset_q  <= '1;
      rx_digitalreset_q <= '1;
      rx_ready_q        <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        rx_state_q[i] <= rx_state_d[i];
        rx_cnt_q[i]   <= rx_cnt_d[i];
      end
      rx_analogreset_q  <= rx_analogreset_d;
      rx_digitalreset_q <= rx_digitalreset_d;
      rx_ready_q        <= rx_ready_d;
    end
  end

  assign rx_analogreset  = rx_analogreset_q;
  assign rx_digitalreset = rx_digitalreset_q;
  assign rx_ready        = rx_ready_q;

endmodule

// File: tb/tb_tr_rst_seq.sv
// Directed self-checking bench for tr_rst_seq (NUM_CH=2, T_PLL_PD=8, T_RX_ANA=4, T_TX_DIG=5, T_RX_LTD=10).
// Edge numbers count rising edges after reset release; outputs are sampled on the falling edge.
module tb_tr_rst_seq;

  localparam int NCH = 2;

  logic           clk_glbl = 1'b0;
  logic           rst_glbl_n = 1'b0;
  logic           pll_powerdown;
  logic           pll_locked = 1'b1;
  logic           pll_cal_busy = 1'b0;
  logic [NCH-1:0] tx_cal_busy = '0;
  logic [NCH-1:0] tx_analogreset, tx_digitalreset, tx_ready;
  logic [NCH-1:0] rx_cal_busy = '0;
  logic [NCH-1:0] rx_is_lockedtodata = '1;
  logic [NCH-1:0] rx_rst_req = '0;
  logic [NCH-1:0] rx_analogreset, rx_digitalreset, rx_ready;

  int n_checks = 0;
  int n_fail   = 0;

  tr_rst_seq #(
    .NUM_CH  (NCH),
    .T_PLL_PD(8),
    .T_RX_ANA(4),
    .T_TX_DIG(5),
    .T_RX_LTD(10)
  ) dut (
    .clk_glbl          (clk_glbl),
    .rst_glbl_n        (rst_glbl_n),
    .pll_powerdown     (pll_powerdown),
    .pll_locked        (pll_locked),
    .pll_cal_busy      (pll_cal_busy),
    .tx_cal_busy       (tx_cal_busy),
    .tx_analogreset    (tx_analogreset),
    .tx_digitalreset   (tx_digitalreset),
    .tx_ready          (tx_ready),
    .rx_cal_busy       (rx_cal_busy),
    .rx_is_lockedtodata(rx_is_lockedtodata),
    .rx_rst_req        (rx_rst_req),
    .rx_analogreset    (rx_analogreset),
    .rx_digitalreset   (rx_digitalreset),
    .rx_ready          (rx_ready)
  );

  always #5 clk_glbl = ~clk_glbl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic pd,
                           input logic [1:0] tx_ana, input logic [1:0] tx_dig, input logic [1:0] tx_rdy,
                           input logic [1:0] rx_ana, input logic [1:0] rx_dig, input logic [1:0] rx_rdy);
    check({tag, ".pll_powerdown"},   pll_powerdown,   pd);
    check({tag, ".tx_analogreset"},  tx_analogreset,  tx_ana);
    check({tag, ".tx_digitalreset"}, tx_digitalreset, tx_dig);
    check({tag, ".tx_ready"},        tx_ready,        tx_rdy);
    check({tag, ".rx_analogreset"},  rx_analogreset,  rx_ana);
    check({tag, ".rx_digitalreset"}, rx_digitalreset, rx_dig);
    check({tag, ".rx_ready"},        rx_ready,        rx_rdy);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_glbl);
      @(negedge clk_glbl);
    end
  endtask

  // Leaves the bench on the falling edge at which reset is released (edge 0).
  task automatic apply_reset();
    @(negedge clk_glbl);
    rst_glbl_n = 1'b0;
    tick(3);
    rst_glbl_n = 1'b1;
  endtask

  // Ideal inputs: TX_CAL entered at edge 8, TX_LOCK at 9, TX_DIG at 10, TX_RDY at 15;
  // RX_CAL at edge 4, RX_LTD at 5, RX_RDY at 15; registered outputs follow one edge later.
  task automatic run_nominal(input string tag);
    check_all({tag, ".rst"}, 1'b1, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00);
    for (int e = 1; e <= 16; e++) begin
      tick(1);
      check_all($sformatf("%s.e%0d", tag, e),
                e <= 8,
                (e <= 9)  ? 2'b11 : 2'b00,
                (e >= 16) ? 2'b00 : 2'b11,
                (e >= 16) ? 2'b11 : 2'b00,
                (e <= 5)  ? 2'b11 : 2'b00,
                (e >= 16) ? 2'b00 : 2'b11,
                (e >= 16) ? 2'b11 : 2'b00);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Power-up sequence with everything ideal.
    apply_reset();
    run_nominal("nom");

    // Soft RX reset of channel 0 at edge 17; channel 1 untouched.
    rx_rst_req = 2'b01;
    tick(1);
    rx_rst_req = 2'b00;
    check("rxreq.e17.rx_ready", rx_ready, 2'b11);
    tick(1);
    check("rxreq.e18.rx_ready", rx_ready, 2'b10);
    check("rxreq.e18.rx_analogreset", rx_analogreset, 2'b01);
    check("rxreq.e18.rx_digitalreset", rx_digitalreset, 2'b01);
    check("rxreq.e18.tx_ready", tx_ready, 2'b11);
    tick(14);
    check("rxreq.e32.rx_ready", rx_ready, 2'b10);
    tick(1);
    check("rxreq.e33.rx_ready", rx_ready, 2'b11);
    check("rxreq.e33.rx_analogreset", rx_analogreset, 2'b00);

    // CDR lock loss on channel 1 while ready.
    rx_is_lockedtodata = 2'b01;
    tick(3);
    check("lockloss.e36.rx_ready", rx_ready, 2'b11);
    tick(1);
    check("lockloss.e37.rx_ready", rx_ready, 2'b01);
    check("lockloss.e37.rx_digitalreset", rx_digitalreset, 2'b10);
`ifdef TR_RST_SEQ_LOCKLOSS_EN
    check("lockloss.e37.rx_analogreset", rx_analogreset, 2'b10);
`else
    check("lockloss.e37.rx_analogreset", rx_analogreset, 2'b00);
`endif
    check("lockloss.e37.tx_ready", tx_ready, 2'b11);

    // Asynchronous reset in the middle of RX_LTD, then a full restart.
    rx_is_lockedtodata = 2'b11;
    apply_reset();
    tick(10);
    check("midrst.e10.rx_analogreset", rx_analogreset, 2'b00);
    check("midrst.e10.tx_analogreset", tx_analogreset, 2'b00);
    rst_glbl_n = 1'b0;
    #1;
    check_all("midrst.async", 1'b1, 2'b11, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00);
    tick(2);
    rst_glbl_n = 1'b1;
    run_nominal("restart");

    // One-cycle pll_locked glitch seen by TX_DIG at count 4: TX_RDY slips from edge 15 to 21.
    apply_reset();
    tick(12);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(3);
    check("glitch.e16.tx_ready", tx_ready, 2'b00);
    check("glitch.e16.rx_ready", rx_ready, 2'b11);
    tick(5);
    check("glitch.e21.tx_ready", tx_ready, 2'b00);
    check("glitch.e21.tx_digitalreset", tx_digitalreset, 2'b11);
    tick(1);
    check("glitch.e22.tx_ready", tx_ready, 2'b11);
    check("glitch.e22.tx_digitalreset", tx_digitalreset, 2'b00);

    // fPLL calibration busy for 30 cycles holds TX in TX_CAL; RX carries on.
    pll_cal_busy = 1'b1;
    apply_reset();
    tick(30);
    check("calbusy.e30.tx_analogreset", tx_analogreset, 2'b11);
    check("calbusy.e30.pll_powerdown", pll_powerdown, 1'b0);
    check("calbusy.e30.rx_ready", rx_ready, 2'b11);
    pll_cal_busy = 1'b0;
    tick(3);
    check("calbusy.e33.tx_analogreset", tx_analogreset, 2'b11);
    tick(1);
    check("calbusy.e34.tx_analogreset", tx_analogreset, 2'b00);
    tick(5);
    check("calbusy.e39.tx_ready", tx_ready, 2'b00);
    tick(1);
    check("calbusy.e40.tx_ready", tx_ready, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
